// File: rtl/cycle_ctrl_pkg.sv
// Shared types and phase constants for the fetch/decode/execute cycle controller.
// Imported by cycle_ctrl and step_edge_det.
package cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [2:0] PH_FETCH  = 3'b001;
    localparam logic [2:0] PH_DECODE = 3'b010;
    localparam logic [2:0] PH_EXEC   = 3'b100;

    // One-hot rotate: fetch -> decode -> execute -> fetch.
    function automatic logic [2:0] ph_next(input logic [2:0] ph);
        return {ph[1:0], ph[2]};
    endfunction

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the Step request, history held in a register.
// Always running so a held Step never retriggers.
module step_edge_det
    import cycle_ctrl_pkg::*;
(
    input  logic Cin,
    input  logic Reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge Cin) begin
        if (Reset) r_q <= 1'b0;
        else       r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/cycle_ctrl.sv
// Fetch/decode/execute cycle controller with run, single-step and halt.
// Optional breakpoint on retired count: define CYCLE_CTRL_BREAK_EN.
module cycle_ctrl
    import cycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Cin,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Step,
    input  logic             Halt_Req,
    input  logic             Wait,
`ifdef CYCLE_CTRL_BREAK_EN
    input  logic             Bp_En,
    input  logic [CNT_W-1:0] Bp_Count,
    output logic             Bp_Hit,
`endif
    output logic [2:0]       Phase,
    output logic [2:0]       Ph_Done,
    output logic             Busy,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_Count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_phase;
    logic [2:0]       r_ph_done;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_step_rise;
    logic             w_adv;
    logic             w_retire;
    logic             w_bp_stop;

    step_edge_det u_step_det (
        .Cin    (Cin),
        .Reset  (Reset),
        .i_d    (Step),
        .o_rise (w_step_rise)
    );

    assign w_adv = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !Wait;
    assign w_retire = w_adv && (r_phase == PH_EXEC);
    assign w_count_inc = r_count + CNT_W'(1);

`ifdef CYCLE_CTRL_BREAK_EN
    assign w_bp_stop = Bp_En && (r_state == ST_RUN) && w_retire
                       && (w_count_inc == Bp_Count);
`else
    assign w_bp_stop = 1'b0;
`endif

    // Leaving HALTED only ever happens from phase fetch, and leaving
    // RUN/STEP only on an execute advance, so halts land on boundaries.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_HALTED: begin
                if (!Halt_Req) begin
                    if (Run)              w_state_nxt = ST_RUN;
                    else if (w_step_rise) w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (w_retire && (!Run || Halt_Req || w_bp_stop))
                    w_state_nxt = ST_HALTED;
            end
            ST_STEP: begin
                if (w_retire) w_state_nxt = ST_HALTED;
            end
            default: w_state_nxt = ST_HALTED;
        endcase
    end

    always_ff @(posedge Cin) begin
        if (Reset) begin
            r_state   <= ST_HALTED;
            r_phase   <= PH_FETCH;
            r_ph_done <= 3'b000;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph_done <= w_adv ? r_phase : 3'b000;
            if (w_adv)    r_phase <= ph_next(r_phase);
            if (w_retire) r_count <= w_count_inc;
        end
    end

`ifdef CYCLE_CTRL_BREAK_EN
    logic r_bp_hit;

    always_ff @(posedge Cin) begin
        if (Reset)
            r_bp_hit <= 1'b0;
        else if (w_bp_stop)
            r_bp_hit <= 1'b1;
        else if ((r_state == ST_HALTED) && (w_state_nxt != ST_HALTED))
            r_bp_hit <= 1'b0;
    end

    assign Bp_Hit = r_bp_hit;
`endif

    assign Phase       = r_phase;
    assign Ph_Done     = r_ph_done;
    assign Busy        = (r_state != ST_HALTED);
    assign Halted      = (r_state == ST_HALTED);
    assign Instr_Count = r_count;

endmodule

// File: tb/tb_cycle_ctrl.sv
// Self-checking bench for cycle_ctrl: vector table, corner sequences,
// then randomized stimulus against a behavioural model.
module tb_cycle_ctrl;

    localparam int CW = 4;

    logic          Cin = 1'b0;
    logic          Reset = 1'b0;
    logic          Run = 1'b0;
    logic          Step = 1'b0;
    logic          Halt_Req = 1'b0;
    logic          Wait = 1'b0;
    logic [2:0]    Phase;
    logic [2:0]    Ph_Done;
    logic          Busy;
    logic          Halted;
    logic [CW-1:0] Instr_Count;
`ifdef CYCLE_CTRL_BREAK_EN
    logic          Bp_En = 1'b0;
    logic [CW-1:0] Bp_Count = '0;
    logic          Bp_Hit;
`endif

    cycle_ctrl #(.CNT_W(CW)) dut (
        .Cin         (Cin),
        .Reset       (Reset),
        .Run         (Run),
        .Step        (Step),
        .Halt_Req    (Halt_Req),
        .Wait        (Wait),
`ifdef CYCLE_CTRL_BREAK_EN
        .Bp_En       (Bp_En),
        .Bp_Count    (Bp_Count),
        .Bp_Hit      (Bp_Hit),
`endif
        .Phase       (Phase),
        .Ph_Done     (Ph_Done),
        .Busy        (Busy),
        .Halted      (Halted),
        .Instr_Count (Instr_Count)
    );

    always #5 Cin = ~Cin;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: mode 0 halted, 1 run, 2 step; phase as index 0..2.
    int m_mode = 0;
    int m_ph = 0;
    int m_cnt = 0;
    int m_done = 0;
    bit m_prev = 0;
    bit m_bphit = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise, adv, retire, bp;
        int nc;
        if (Reset) begin
            m_mode = 0; m_ph = 0; m_cnt = 0; m_done = 0;
            m_prev = 0; m_bphit = 0;
            return;
        end
        rise = Step && !m_prev;
        m_prev = Step;
        adv = (m_mode != 0) && !Wait;
        retire = adv && (m_ph == 2);
        nc = retire ? (m_cnt + 1) % (1 << CW) : m_cnt;
        bp = 0;
`ifdef CYCLE_CTRL_BREAK_EN
        bp = (m_mode == 1) && retire && Bp_En && (nc == int'(Bp_Count));
`endif
        m_done = adv ? (1 << m_ph) : 0;
        if (adv) m_ph = (m_ph + 1) % 3;
        m_cnt = nc;
        if (m_mode == 0) begin
            if (!Halt_Req && (Run || rise)) begin
                m_mode = Run ? 1 : 2;
                m_bphit = 0;
            end
        end else if (m_mode == 1) begin
            if (retire && (!Run || Halt_Req || bp)) m_mode = 0;
            if (bp) m_bphit = 1;
        end else begin
            if (retire) m_mode = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge Cin);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_phase"}, int'(Phase), 1 << m_ph);
        chk({tag, "_done"}, int'(Ph_Done), m_done);
        chk({tag, "_halted"}, int'(Halted), (m_mode == 0) ? 1 : 0);
        chk({tag, "_busy"}, int'(Busy), (m_mode != 0) ? 1 : 0);
        chk({tag, "_count"}, int'(Instr_Count), m_cnt);
`ifdef CYCLE_CTRL_BREAK_EN
        chk({tag, "_bphit"}, int'(Bp_Hit), int'(m_bphit));
`endif
    endtask

    task automatic set_in(input bit r, input bit rn, input bit s,
                          input bit h, input bit w);
        Reset = r; Run = rn; Step = s; Halt_Req = h; Wait = w;
    endtask

    typedef struct {
        bit rst, run, stp, hlt, wt;
        int ph, dn, hd, cnt;
    } vec_t;

    function automatic vec_t mk(bit rst, bit run, bit stp, bit hlt, bit wt,
                                int ph, int dn, int hd, int cnt);
        vec_t v;
        v.rst = rst; v.run = run; v.stp = stp; v.hlt = hlt; v.wt = wt;
        v.ph = ph; v.dn = dn; v.hd = hd; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[20];
    bit   found;

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 2, 1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 4, 2, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 1, 4, 0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 2, 1, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 4, 2, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 4, 1, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 2);
        tbl[10] = mk(0, 0, 1, 0, 0, 1, 0, 0, 2);
        tbl[11] = mk(0, 0, 1, 0, 0, 2, 1, 0, 2);
        tbl[12] = mk(0, 0, 1, 0, 0, 4, 2, 0, 2);
        tbl[13] = mk(0, 0, 1, 0, 0, 1, 4, 1, 3);
        tbl[14] = mk(0, 0, 1, 0, 0, 1, 0, 1, 3);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 1, 3);
        tbl[16] = mk(0, 1, 0, 1, 0, 1, 0, 1, 3);
        tbl[17] = mk(0, 1, 0, 0, 0, 1, 0, 0, 3);
        tbl[18] = mk(0, 1, 0, 0, 0, 2, 1, 0, 3);
        tbl[19] = mk(1, 1, 0, 0, 0, 1, 0, 1, 0);

        @(posedge Cin);
        #1;
        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].rst, tbl[i].run, tbl[i].stp, tbl[i].hlt, tbl[i].wt);
            cycle();
            chk($sformatf("vec%0d_phase", i), int'(Phase), tbl[i].ph);
            chk($sformatf("vec%0d_done", i), int'(Ph_Done), tbl[i].dn);
            chk($sformatf("vec%0d_halted", i), int'(Halted), tbl[i].hd);
            chk($sformatf("vec%0d_busy", i), int'(Busy), 1 - tbl[i].hd);
            chk($sformatf("vec%0d_count", i), int'(Instr_Count), tbl[i].cnt);
        end

        // Wait held four cycles in decode freezes everything.
        set_in(0, 1, 0, 0, 0);
        cycle();
        cycle();
        chk("wait_pre_phase", int'(Phase), 2);
        Wait = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("wait%0d_phase", i), int'(Phase), 2);
            chk($sformatf("wait%0d_done", i), int'(Ph_Done), 0);
            chk($sformatf("wait%0d_count", i), int'(Instr_Count), 0);
        end
        Wait = 0;
        cycle();
        chk("wait_post_phase", int'(Phase), 4);
        chk("wait_post_done", int'(Ph_Done), 2);

        // Counter wrap at 2^CW.
        set_in(1, 0, 0, 0, 0);
        cycle();
        set_in(0, 1, 0, 0, 0);
        cycle();
        for (int i = 0; i < 45; i++) cycle();
        chk("wrap_pre_count", int'(Instr_Count), 15);
        chk("wrap_pre_phase", int'(Phase), 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("wrap_count", int'(Instr_Count), 0);
        chk("wrap_phase", int'(Phase), 1);
        chk("wrap_done", int'(Ph_Done), 4);

`ifdef CYCLE_CTRL_BREAK_EN
        set_in(1, 0, 0, 0, 0);
        cycle();
        Bp_En = 1;
        Bp_Count = 4'd5;
        set_in(0, 1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (Halted) found = 1;
        end
        chk("bp_halt_seen", int'(found), 1);
        chk("bp_count", int'(Instr_Count), 5);
        chk("bp_hit", int'(Bp_Hit), 1);
        chk("bp_phase", int'(Phase), 1);
        cycle();
        chk("bp_hit_clear", int'(Bp_Hit), 0);
        chk("bp_resume", int'(Halted), 0);
        Bp_En = 0;
`endif

        // Randomized run against the model.
        set_in(1, 0, 0, 0, 0);
        cycle();
        chk_model("rst");
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom_range(0, 199) == 0);
            Run      = ($urandom_range(0, 3) != 0) ? Run : ~Run;
            Step     = ($urandom_range(0, 2) == 0) ? ~Step : Step;
            Halt_Req = ($urandom_range(0, 9) == 0);
            Wait     = ($urandom_range(0, 3) == 0);
`ifdef CYCLE_CTRL_BREAK_EN
            Bp_En    = ($urandom_range(0, 3) == 0);
            Bp_Count = CW'($urandom_range(0, 15));
`endif
            cycle();
            chk_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
